// File: rtl/serial_shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_shift_ctrl_pkg
// Brief    : State encoding and default word width shared by the serial
//            shift controller and its datapath.
// Revision : 1.0
// ============================================================================
package serial_shift_ctrl_pkg;

    localparam int DEF_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_chain
// Brief    : W-bit parallel-load, left-shifting register; Q_msb taps the
//            stage that feeds the serial output next.
// Revision : 1.0
// ============================================================================
module shift_reg_chain
    import serial_shift_ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Load,
    input  logic         Shift_En,
    input  logic [W-1:0] D,
    output logic         Q_msb
);

    logic [W-1:0] r_shreg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_shreg <= '0;
        end else if (Load) begin
            r_shreg <= D;
        end else if (Shift_En) begin
            r_shreg <= r_shreg << 1;
        end
    end

    assign Q_msb = r_shreg[W-1];

endmodule
`default_nettype wire

// File: rtl/serial_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_shift_ctrl
// Brief    : Captures a W-bit word on Start/Ready and serialises it MSB-first,
//            pulsing Done at frame end. Define SERIAL_PARITY_EN to append an
//            even-parity bit to every frame.
// Revision : 1.0
// ============================================================================
module serial_shift_ctrl
    import serial_shift_ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         Start,
    input  logic [W-1:0] DataIn,
    output logic         Ready,
    output logic         Busy,
    output logic         Shift_En,
    output logic         SerOut,
    output logic         Done
);

    localparam int               CNT_W  = $clog2(W) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_last;
    logic             w_chain_msb;
    logic             w_tail_bit;
    logic [W-1:0]     w_load_word;

    assign w_last      = (r_count == C_LAST);
    // MSB leaves on the capture edge itself, so the chain holds the rest.
    assign w_load_word = DataIn << 1;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        Ready       = 1'b0;
        Busy        = 1'b0;
        Shift_En    = 1'b0;
        Done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                Ready = 1'b1;
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (w_last) begin
`ifdef SERIAL_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SERIAL_PARITY_EN
            S_PARITY: begin
                Busy        = 1'b1;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                Done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (Shift_En) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

`ifdef SERIAL_PARITY_EN
    logic r_parity;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^DataIn;
        end
    end

    assign w_tail_bit = r_parity;
`else
    assign w_tail_bit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            SerOut <= 1'b0;
        end else if (w_load) begin
            SerOut <= DataIn[W-1];
        end else if (Shift_En) begin
            SerOut <= w_last ? w_tail_bit : w_chain_msb;
        end else begin
            SerOut <= 1'b0;
        end
    end

    shift_reg_chain #(
        .W (W)
    ) u_chain (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Load     (w_load),
        .Shift_En (Shift_En),
        .D        (w_load_word),
        .Q_msb    (w_chain_msb)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_shift_ctrl
// Brief    : Directed bench for serial_shift_ctrl (W=4 plus a W=1 instance).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_serial_shift_ctrl;

    localparam int W = 4;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int         NB     = W + PAR;
    localparam int         P      = W + 2 + PAR;
    localparam logic [4:0] IDLE_V = 5'b10000;  // {Ready,Busy,Shift_En,SerOut,Done}

    logic         Clock = 1'b0;
    logic         Resetn;
    logic         Start;
    logic [W-1:0] DataIn;
    logic         Ready, Busy, Shift_En, SerOut, Done;

    logic         Start1, DataIn1;
    logic         Ready1, Busy1, Shift_En1, SerOut1, Done1;

    always #5 Clock = ~Clock;

    serial_shift_ctrl #(.W(W)) u_dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .DataIn   (DataIn),
        .Ready    (Ready),
        .Busy     (Busy),
        .Shift_En (Shift_En),
        .SerOut   (SerOut),
        .Done     (Done)
    );

    serial_shift_ctrl #(.W(1)) u_dut1 (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start1),
        .DataIn   (DataIn1),
        .Ready    (Ready1),
        .Busy     (Busy1),
        .Shift_En (Shift_En1),
        .SerOut   (SerOut1),
        .Done     (Done1)
    );

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: an accepted word becomes a list of per-cycle output tuples.
    logic [4:0] q[$];
    logic [4:0] cur = IDLE_V;

    initial forever begin
        @(posedge Clock or negedge Resetn);
        if (!Resetn) begin
            q.delete();
            cur = IDLE_V;
        end else begin
            if (cur[4] && Start === 1'b1) begin
                for (int k = W - 1; k >= 0; k--)
                    q.push_back({1'b0, 1'b1, 1'b1, DataIn[k], 1'b0});
                if (PAR != 0)
                    q.push_back({1'b0, 1'b1, 1'b0, ^DataIn, 1'b0});
                q.push_back(5'b00001);
            end
            cur = (q.size() != 0) ? q.pop_front() : IDLE_V;
        end
    end

    initial forever begin
        @(negedge Clock);
        if (chk_en) begin
            total++;
            if ({Ready, Busy, Shift_En, SerOut, Done} !== cur) begin
                bad++;
                $display("FAIL model_cycle t=%0t: got %b expected %b",
                         $time, {Ready, Busy, Shift_En, SerOut, Done}, cur);
            end
        end
    end

    // One Start pulse; records serial bits, Done cycle (1 = cycle after capture) and Ready after Done.
    task automatic run_frame(input logic [W-1:0] d, input int inj,
                             output logic [NB-1:0] bits, output int done_at, output logic rdy_after);
        Start  = 1'b1;
        DataIn = d;
        @(negedge Clock);
        Start     = 1'b0;
        DataIn    = ~d;
        bits      = '0;
        done_at   = -1;
        rdy_after = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= NB) bits = (bits << 1) | NB'(SerOut);
            if (Done === 1'b1 && done_at < 0) done_at = c;
            if (done_at >= 0 && c == done_at + 1) rdy_after = Ready;
            if (c == inj) begin
                Start  = 1'b1;
                DataIn = '1;
            end else if (c == inj + 1) begin
                Start  = 1'b0;
                DataIn = ~d;
            end
            @(negedge Clock);
        end
    endtask

    logic [NB-1:0] bits;
    logic [P-1:0]  run_bits;
    int            done_at;
    int            dones;
    logic          rdy_after;

    initial begin
        Resetn  = 1'b0;
        Start   = 1'b1;
        DataIn  = '1;
        Start1  = 1'b0;
        DataIn1 = 1'b0;

        // Reset held with Start high
        @(negedge Clock);
        chk_en = 1'b1;
        @(negedge Clock);
        check("rst_outputs", {Ready, Busy, Shift_En, SerOut, Done}, 5'b10000);
        check("rst_outputs_w1", {Ready1, Busy1, Shift_En1, SerOut1, Done1}, 5'b10000);
        Start  = 1'b0;
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);

        // Single frame 1011
        run_frame(4'b1011, -5, bits, done_at, rdy_after);
`ifdef SERIAL_PARITY_EN
        check("f1011_bits", bits, 5'b10111);
        check("f1011_done_at", done_at, 6);
`else
        check("f1011_bits", bits, 4'b1011);
        check("f1011_done_at", done_at, 5);
`endif
        check("f1011_ready_after", rdy_after, 1'b1);

        // Start held high, 0110 back to back
        Start  = 1'b1;
        DataIn = 4'b0110;
        dones  = 0;
        run_bits = '0;
        for (int c = 1; c <= 3 * P; c++) begin
            @(negedge Clock);
            if (c <= P) run_bits = (run_bits << 1) | P'(SerOut);
            if (Done === 1'b1) dones++;
        end
        Start = 1'b0;
`ifdef SERIAL_PARITY_EN
        check("held_first_period", run_bits, 7'b0110000);
`else
        check("held_first_period", run_bits, 6'b011000);
`endif
        check("held_done_count", dones, 3);
        repeat (3) @(negedge Clock);

        // Start with 1111 mid-frame of 1000 is ignored
        run_frame(4'b1000, 2, bits, done_at, rdy_after);
`ifdef SERIAL_PARITY_EN
        check("ignore_bits", bits, 5'b10001);
`else
        check("ignore_bits", bits, 4'b1000);
`endif

        // Asynchronous reset mid-frame of 1101
        Start  = 1'b1;
        DataIn = 4'b1101;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        check("abort_bit2", SerOut, 1'b1);
        #2 Resetn = 1'b0;
        #1 check("abort_async", {Ready, Busy, Shift_En, SerOut, Done}, 5'b10000);
        @(negedge Clock);
        Resetn = 1'b1;
        dones  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clock);
            if (Done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_frame(4'b0011, -5, bits, done_at, rdy_after);
`ifdef SERIAL_PARITY_EN
        check("after_abort_bits", bits, 5'b00110);
`else
        check("after_abort_bits", bits, 4'b0011);
`endif

        // Frame 1001 (parity bit 0 when enabled)
        run_frame(4'b1001, -5, bits, done_at, rdy_after);
`ifdef SERIAL_PARITY_EN
        check("f1001_bits", bits, 5'b10010);
        check("f1001_done_at", done_at, 6);
`else
        check("f1001_bits", bits, 4'b1001);
        check("f1001_done_at", done_at, 5);
`endif

        // W=1 instance: single-cycle SHIFT
        Start1  = 1'b1;
        DataIn1 = 1'b1;
        @(negedge Clock);
        Start1  = 1'b0;
        DataIn1 = 1'b0;
        check("w1_shift", {Ready1, Busy1, Shift_En1, SerOut1, Done1}, 5'b01110);
        @(negedge Clock);
`ifdef SERIAL_PARITY_EN
        check("w1_parity", {Ready1, Busy1, Shift_En1, SerOut1, Done1}, 5'b01010);
        @(negedge Clock);
`endif
        check("w1_done", {Ready1, Busy1, Shift_En1, SerOut1, Done1}, 5'b00001);
        @(negedge Clock);
        check("w1_idle", {Ready1, Busy1, Shift_En1, SerOut1, Done1}, 5'b10000);

        repeat (2) @(negedge Clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
